flappy_game_sequencer: RTL and testbench

Game-level controller that sequences `flappybirdcore` and drives its `reset`, `start`, `flap` and `tick` inputs. Raw board buttons are synchronised and debounced here, and game-update ticks are generated only while a round is live. The block runs the IDLE→PLAY→DYING→OVER round lifecycle and keeps a persistent high score for the renderer. It sits in `flappybird_top` between the buttons, the core and the display mux, replacing the free-running tick divider.

---
 rtl/flappy_game_sequencer.sv | 146 ++++++++++++++
 tb/tb_flappy_game_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_sequencer.sv
// Round sequencer for the flappy bird core: button front end,
// live-only tick divider, round lifecycle and persistent high score.
module flappy_game_sequencer #(
   parameter int unsigned TICK_DIV            = 1048576,
   parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
   parameter int unsigned GAMEOVER_TICKS      = 190,
   parameter int unsigned FLAP_COOLDOWN_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_start,
   input  logic       btn_flap,
   input  logic       hit,
   input  logic [7:0] score,
   output logic       core_reset,
   output logic       core_start,
   output logic       core_flap,
   output logic       tick,
   output logic [1:0] state,
   output logic [7:0] high_score,
   output logic       new_record
);

   localparam int unsigned TDW = $clog2(TICK_DIV + 1);
   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned GW  = $clog2(GAMEOVER_TICKS + 1);
   localparam int unsigned CW  = $clog2(FLAP_COOLDOWN_TICKS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PLAY  = 2'b01,
      DYING = 2'b10,
      OVER  = 2'b11
   } state_t;

   state_t cur, nxt;

   // bit 0 = start button, bit 1 = flap button
   logic [1:0]     raw, sync1, sync2, db, db_q, press;
   logic [DBW-1:0] cnt [2];

   logic           live, live_nxt, tick_evt;
   logic [TDW-1:0] div;
   logic [GW-1:0]  die_cnt;
   logic [CW-1:0]  cool;
   logic           pending;

   assign raw   = {btn_flap, btn_start};
   assign press = db & ~db_q;
   assign state = cur;

   // Synchronise both buttons and accept a new level only after it has held steady
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         db_q  <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         db_q  <= db;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               db[i]  <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign live     = (cur == PLAY) || (cur == DYING);
   assign live_nxt = (nxt == PLAY) || (nxt == DYING);
   assign tick_evt = live && (div == TDW'(TICK_DIV - 1));

   // Round lifecycle next-state decode
   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:    if (press[0]) nxt = PLAY;
         PLAY:    if (hit) nxt = DYING;
         DYING:   if (tick && die_cnt == GW'(GAMEOVER_TICKS - 1)) nxt = OVER;
         OVER:    if (press[0]) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // State, tick divider, dying tick count, core control and score bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur        <= IDLE;
         div        <= '0;
         tick       <= 1'b0;
         die_cnt    <= '0;
         core_reset <= 1'b1;
         core_start <= 1'b0;
         high_score <= '0;
         new_record <= 1'b0;
      end else begin
         cur        <= nxt;
         tick       <= tick_evt;
         div        <= (live && live_nxt && !tick_evt) ? div + 1'b1 : '0;
         die_cnt    <= (cur != DYING) ? '0 : (tick ? die_cnt + 1'b1 : die_cnt);
         core_reset <= (nxt == IDLE);
         core_start <= (cur == IDLE) && (nxt == PLAY);
         if (cur == DYING && nxt == OVER) begin
            if (score > high_score) begin
               high_score <= score;
               new_record <= 1'b1;
            end else begin
               new_record <= 1'b0;
            end
         end else if (cur == OVER && nxt == IDLE) begin
            new_record <= 1'b0;
         end
      end
   end

   // Flap request latch, issue on a tick, then hold off further presses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending   <= 1'b0;
         cool      <= '0;
         core_flap <= 1'b0;
      end else begin
         core_flap <= 1'b0;
         if (cur != PLAY || hit) begin
            pending <= 1'b0;
            cool    <= '0;
         end else if (tick_evt && pending) begin
            core_flap <= 1'b1;
            pending   <= 1'b0;
            cool      <= CW'(FLAP_COOLDOWN_TICKS);
         end else begin
            if (tick_evt && cool != '0) cool <= cool - 1'b1;
            if (press[1] && !pending && cool == '0) pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_flappy_game_sequencer.sv
// Bench for flappy_game_sequencer: directed round scenarios plus
// randomized buttons/hits checked against a cycle-stamp reference model.
module tb_flappy_game_sequencer;

   localparam int TD = 8;
   localparam int D  = 4;
   localparam int G  = 3;
   localparam int F  = 2;

   logic       clk = 1'b0;
   logic       reset_n, btn_start, btn_flap, hit;
   logic [7:0] score;
   logic       core_reset, core_start, core_flap, tick, new_record;
   logic [1:0] state;
   logic [7:0] high_score;

   flappy_game_sequencer #(
      .TICK_DIV(TD),
      .DEBOUNCE_CYCLES(D),
      .GAMEOVER_TICKS(G),
      .FLAP_COOLDOWN_TICKS(F)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .btn_start(btn_start),
      .btn_flap(btn_flap),
      .hit(hit),
      .score(score),
      .core_reset(core_reset),
      .core_start(core_start),
      .core_flap(core_flap),
      .tick(tick),
      .state(state),
      .high_score(high_score),
      .new_record(new_record)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_start, n_flap, n_flap_bad;

   // reference model state (describes the current cycle)
   int       cyc_n = 0;
   int       m_st, m_hs, die_seen, live_start, last_issue;
   bit       m_nr, m_tick, m_flap, m_start, pend;
   bit       db_s, db_f, dbp_s, dbp_f;
   bit [D+1:0] h_s, h_f;

   typedef struct {
      logic [7:0] sc;
      logic [7:0] hs;
      logic       nr;
   } row_t;
   row_t rows [3];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
   endtask

   task automatic model_reset();
      m_st = 0; m_hs = 0; m_nr = 0; m_tick = 0; m_flap = 0; m_start = 0;
      pend = 0; die_seen = 0; live_start = 0; last_issue = -1000000;
      db_s = 0; db_f = 0; dbp_s = 0; dbp_f = 0; h_s = '0; h_f = '0;
   endtask

   // advance the model from the current cycle to the next one
   task automatic model_step();
      bit ps, pf, tk_next, fl_next;
      int nst;
      if (!reset_n) begin
         model_reset();
         cyc_n++;
         return;
      end
      ps = db_s & ~dbp_s;
      pf = db_f & ~dbp_f;
      dbp_s = db_s;
      dbp_f = db_f;
      h_s = {h_s[D:0], btn_start};
      h_f = {h_f[D:0], btn_flap};
      if (&h_s[D+1:2]) db_s = 1; else if (!(|h_s[D+1:2])) db_s = 0;
      if (&h_f[D+1:2]) db_f = 1; else if (!(|h_f[D+1:2])) db_f = 0;
      tk_next = (m_st == 1 || m_st == 2) && ((cyc_n + 1 - live_start) % TD == 0);
      fl_next = 0;
      nst = m_st;
      case (m_st)
         0: if (ps) begin
               nst = 1;
               live_start = cyc_n + 1;
               last_issue = -1000000;
               pend = 0;
            end
         1: if (hit) begin
               nst = 2;
               pend = 0;
               die_seen = 0;
            end else if (pend && tk_next) begin
               fl_next = 1;
               pend = 0;
               last_issue = cyc_n + 1;
            end else if (pf && !pend && (cyc_n - last_issue >= F * TD)) begin
               pend = 1;
            end
         2: if (m_tick) begin
               die_seen++;
               if (die_seen == G) begin
                  nst = 3;
                  if (int'(score) > m_hs) begin
                     m_hs = int'(score);
                     m_nr = 1;
                  end else begin
                     m_nr = 0;
                  end
               end
            end
         default: if (ps) begin
               nst = 0;
               m_nr = 0;
            end
      endcase
      m_start = (m_st == 0) && (nst == 1);
      m_flap = fl_next;
      m_tick = tk_next;
      m_st = nst;
      cyc_n++;
   endtask

   // one clock: compare against the model, step it, return after the edge
   task automatic cyc();
      logic [14:0] dv, mv;
      @(negedge clk);
      if (!reset_n) model_reset();
      dv = {state, core_reset, core_start, core_flap, tick, high_score, new_record};
      mv = {2'(m_st), m_st == 0, m_start, m_flap, m_tick, 8'(m_hs), m_nr};
      chk("model_outputs", 32'(dv), 32'(mv));
      if (core_start) n_start++;
      if (core_flap) n_flap++;
      if (core_flap && !tick) n_flap_bad++;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
      int k = 0;
      while (state !== s && k < budget) begin
         cyc();
         k++;
      end
      chk(nm, 32'(state), 32'(s));
   endtask

   task automatic press_btn(input bit s, input bit f);
      btn_start = s;
      btn_flap  = f;
      repeat (6) cyc();
      btn_start = 0;
      btn_flap  = 0;
      repeat (8) cyc();
   endtask

   initial begin
      int start_at, first_tick, nd, no;
      bit done;
      rows[0] = '{8'd5, 8'd5, 1'b1};
      rows[1] = '{8'd3, 8'd5, 1'b0};
      rows[2] = '{8'd5, 8'd5, 1'b0};
      reset_n = 0; btn_start = 0; btn_flap = 0; hit = 0; score = 0;
      n_start = 0; n_flap = 0; n_flap_bad = 0;
      model_reset();
      repeat (3) cyc();
      chk("rst_state", 32'(state), 0);
      chk("rst_core_reset", 32'(core_reset), 1);
      chk("rst_high_score", 32'(high_score), 0);
      chk("rst_pulses", 32'({core_start, core_flap, tick, new_record}), 0);
      reset_n = 1;
      repeat (2) cyc();

      // start press: one core_start, first tick 8 cycles on
      n_start = 0; start_at = -1; first_tick = -1;
      for (int i = 0; i < 30; i++) begin
         btn_start = (i < 10);
         cyc();
         if (core_start && start_at < 0) begin
            start_at = i;
            chk("start_state", 32'(state), 1);
            chk("start_core_reset", 32'(core_reset), 0);
         end
         if (tick && first_tick < 0) first_tick = i;
      end
      chk("start_pulses", 32'(n_start), 1);
      chk("first_tick_delay", 32'(first_tick - start_at), 8);

      // short glitch is filtered, a long press gives one flap on a tick
      n_flap = 0;
      btn_flap = 1; cyc(); cyc(); btn_flap = 0;
      repeat (20) cyc();
      chk("glitch_no_flap", 32'(n_flap), 0);
      n_flap = 0; n_flap_bad = 0;
      btn_flap = 1; repeat (10) cyc(); btn_flap = 0;
      repeat (30) cyc();
      chk("long_press_flaps", 32'(n_flap), 1);
      chk("flap_off_tick", 32'(n_flap_bad), 0);

      // three presses: middle one lands in the cooldown
      repeat (20) cyc();
      n_flap = 0;
      for (int i = 0; i < 60; i++) begin
         btn_flap = (i < 5) || (i >= 12 && i < 17) || (i >= 32 && i < 37);
         cyc();
      end
      btn_flap = 0;
      repeat (20) cyc();
      chk("cooldown_flaps", 32'(n_flap), 2);
      chk("cooldown_off_tick", 32'(n_flap_bad), 0);
      chk("cooldown_state", 32'(state), 1);

      // hit sampled together with the pending flap's tick
      repeat (20) cyc();
      score = 0; done = 0;
      btn_flap = 1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (i == 5) btn_flap = 0;
         if (pend && ((cyc_n + 1 - live_start) % TD == 0)) begin
            hit = 1;
            done = 1;
         end
         cyc();
      end
      hit = 0; btn_flap = 0;
      chk("hit_align", 32'(done), 1);
      chk("hit_flap_dropped", 32'(core_flap), 0);
      chk("hit_tick", 32'(tick), 1);
      chk("hit_dying", 32'(state), 2);
      nd = (tick && state == 2) ? 1 : 0;
      no = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (tick && state == 2) nd++;
         if (tick && state == 3) no++;
      end
      chk("dying_ticks", 32'(nd), 3);
      chk("over_no_ticks", 32'(no), 0);
      chk("over_state", 32'(state), 3);
      chk("zero_score_hs", 32'(high_score), 0);
      chk("zero_score_nr", 32'(new_record), 0);

      // rounds from the table; start+flap together in IDLE
      for (int r = 0; r < 3; r++) begin
         press_btn(1, 0);
         wait_state(2'd0, 20, "round_idle");
         chk("round_nr_clear", 32'(new_record), 0);
         chk("round_core_reset", 32'(core_reset), 1);
         n_flap = 0;
         press_btn(1, 1);
         wait_state(2'd1, 20, "round_play");
         score = rows[r].sc;
         repeat (5) cyc();
         hit = 1; cyc(); hit = 0;
         wait_state(2'd3, 60, "round_over");
         chk("round_high_score", 32'(high_score), 32'(rows[r].hs));
         chk("round_new_record", 32'(new_record), 32'(rows[r].nr));
         chk("round_no_flap", 32'(n_flap), 0);
      end

      // reset in the middle of DYING
      press_btn(1, 0);
      press_btn(1, 0);
      wait_state(2'd1, 20, "rst_play");
      hit = 1; cyc(); hit = 0;
      repeat (3) cyc();
      chk("pre_rst_state", 32'(state), 2);
      chk("pre_rst_hs", 32'(high_score), 5);
      reset_n = 0;
      cyc();
      chk("mid_rst_state", 32'(state), 0);
      chk("mid_rst_core_reset", 32'(core_reset), 1);
      chk("mid_rst_hs", 32'(high_score), 0);
      chk("mid_rst_pulses", 32'({core_start, core_flap, tick, new_record}), 0);
      reset_n = 1;
      cyc();

      // randomized buttons, hits and scores against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
         if ($urandom_range(0, 4) == 0) btn_flap = ~btn_flap;
         hit = ($urandom_range(0, 63) == 0);
         score = 8'($urandom);
         reset_n = ($urandom_range(0, 1999) != 0);
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
